// File: rtl/mem_stage.sv
// Memory pipeline stage: runs Lw/Sw over a req/ack bus and passes other EX results to writeback.
// Optional bus-timeout path enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [5:0]  ex_op,
  input  logic [31:0] ex_memAddr,
  input  logic [31:0] ex_memData,
  input  logic [31:0] ex_regcData,
  input  logic        ex_regcWrite,
  input  logic [4:0]  ex_regcAddr,
  input  logic [31:0] ex_excptype,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_regcData,
  output logic        wb_regcWrite,
  output logic [4:0]  wb_regcAddr,
  output logic [31:0] wb_excptype,
  output logic        stall_o
);

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;

  logic       lat_lw;
  logic       lat_regcWrite;
  logic [4:0] lat_regcAddr;

  logic transfer, is_lw, is_sw, is_mem, has_exc, misaligned, start_access, timeout;

  assign ex_ready     = (state == IDLE);
  assign stall_o      = ~ex_ready;
  assign transfer     = ex_valid & ex_ready;
  assign is_lw        = (ex_op == OP_LW);
  assign is_sw        = (ex_op == OP_SW);
  assign is_mem       = is_lw | is_sw;
  assign has_exc      = (ex_excptype != '0);
  assign misaligned   = (ex_memAddr[1:0] != 2'b00);
  assign start_access = transfer & is_mem & ~has_exc & ~misaligned;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] busy_cnt;

  // Counter reads 0 on the first BUSY cycle, so timeout fires after TIMEOUT_CYCLES BUSY cycles.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE) busy_cnt <= '0;
    else                      busy_cnt <= busy_cnt + 1'b1;
  end

  assign timeout = (state == BUSY) & ~mem_ack & (busy_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_access) state_nxt = BUSY;
      BUSY:    if (mem_ack || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      wb_valid      <= 1'b0;
      wb_regcData   <= '0;
      wb_regcWrite  <= 1'b0;
      wb_regcAddr   <= '0;
      wb_excptype   <= '0;
      lat_lw        <= 1'b0;
      lat_regcWrite <= 1'b0;
      lat_regcAddr  <= '0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            if (!is_mem || has_exc) begin
              wb_valid     <= 1'b1;
              wb_regcData  <= ex_regcData;
              wb_regcWrite <= ex_regcWrite & ~has_exc;
              wb_regcAddr  <= ex_regcAddr;
              wb_excptype  <= ex_excptype;
            end else if (misaligned) begin
              wb_valid     <= 1'b1;
              wb_regcData  <= '0;
              wb_regcWrite <= 1'b0;
              wb_regcAddr  <= ex_regcAddr;
              wb_excptype  <= is_lw ? 32'h0000_0010 : 32'h0000_0020;
            end else begin
              mem_req       <= 1'b1;
              mem_we        <= is_sw;
              mem_addr      <= {ex_memAddr[31:2], 2'b00};
              mem_wdata     <= ex_memData;
              lat_lw        <= is_lw;
              lat_regcWrite <= ex_regcWrite;
              lat_regcAddr  <= ex_regcAddr;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            wb_valid     <= 1'b1;
            wb_regcData  <= lat_lw ? mem_rdata : '0;
            wb_regcWrite <= lat_lw & lat_regcWrite;
            wb_regcAddr  <= lat_regcAddr;
            wb_excptype  <= '0;
          end else if (timeout) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            wb_valid     <= 1'b1;
            wb_regcData  <= '0;
            wb_regcWrite <= 1'b0;
            wb_regcAddr  <= lat_regcAddr;
            wb_excptype  <= 32'h0000_0400;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (default build, timeout path disabled).
module tb_mem_stage;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_OR = 6'b100101;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [5:0]  ex_op;
  logic [31:0] ex_memAddr, ex_memData, ex_regcData, ex_excptype;
  logic        ex_regcWrite;
  logic [4:0]  ex_regcAddr;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        wb_valid, wb_regcWrite, stall_o;
  logic [31:0] wb_regcData, wb_excptype;
  logic [4:0]  wb_regcAddr;

  int total = 0;
  int bad = 0;

  mem_stage #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_memAddr(ex_memAddr), .ex_memData(ex_memData), .ex_regcData(ex_regcData),
    .ex_regcWrite(ex_regcWrite), .ex_regcAddr(ex_regcAddr), .ex_excptype(ex_excptype),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_regcData(wb_regcData), .wb_regcWrite(wb_regcWrite),
    .wb_regcAddr(wb_regcAddr), .wb_excptype(wb_excptype), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] rdat, input logic wr, input logic [4:0] ra,
                       input logic [31:0] exc);
    ex_valid = 1'b1; ex_op = op; ex_memAddr = addr; ex_memData = data;
    ex_regcData = rdat; ex_regcWrite = wr; ex_regcAddr = ra; ex_excptype = exc;
  endtask

  task automatic test_reset();
    rst = 1'b1; ex_valid = 1'b0; ex_op = '0; ex_memAddr = '0; ex_memData = '0;
    ex_regcData = '0; ex_regcWrite = 1'b0; ex_regcAddr = '0; ex_excptype = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", mem_req); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wbv got %b want 0", wb_valid); end
    total++; if ({wb_regcData, wb_excptype, wb_regcAddr, wb_regcWrite, mem_we} !== '0) begin
      bad++; $display("FAIL reset_outs got %h/%h/%h want 0", wb_regcData, wb_excptype, wb_regcAddr); end
    total++; if (ex_ready !== 1'b1 || stall_o !== 1'b0) begin
      bad++; $display("FAIL reset_ready got %b/%b want 1/0", ex_ready, stall_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_alu();
    drive(OP_OR, 32'h0, 32'h0, 32'h0000_1234, 1'b1, 5'd3, 32'h0);
    tick();
    ex_valid = 1'b0;
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu_wbv got %b want 1", wb_valid); end
    total++; if (wb_regcData !== 32'h1234 || wb_regcWrite !== 1'b1 || wb_regcAddr !== 5'd3 || wb_excptype !== 32'h0) begin
      bad++; $display("FAIL alu_wb got %h/%b/%0d/%h want 1234/1/3/0", wb_regcData, wb_regcWrite, wb_regcAddr, wb_excptype); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL alu_req got %b want 0", mem_req); end
    tick();
    total++; if (wb_valid !== 1'b0 || wb_regcData !== 32'h1234) begin
      bad++; $display("FAIL alu_hold got %b/%h want 0/1234", wb_valid, wb_regcData); end
  endtask

  task automatic test_load();
    drive(OP_LW, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 5'd5, 32'h0);
    tick();
    ex_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
        bad++; $display("FAIL lw_req c%0d got %b/%b/%h want 1/0/100", c, mem_req, mem_we, mem_addr); end
      total++; if (stall_o !== 1'b1 || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin
        bad++; $display("FAIL lw_stall c%0d got %b/%b/%b want 1/0/0", c, stall_o, ex_ready, wb_valid); end
      if (c == 3) begin mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; end
      tick();
    end
    mem_ack = 1'b0; mem_rdata = '0;
    total++; if (wb_valid !== 1'b1 || wb_regcData !== 32'hDEAD_BEEF || wb_regcWrite !== 1'b1 || wb_regcAddr !== 5'd5) begin
      bad++; $display("FAIL lw_wb got %b/%h/%b/%0d want 1/deadbeef/1/5", wb_valid, wb_regcData, wb_regcWrite, wb_regcAddr); end
    total++; if (mem_req !== 1'b0 || ex_ready !== 1'b1 || wb_excptype !== 32'h0) begin
      bad++; $display("FAIL lw_done got %b/%b/%h want 0/1/0", mem_req, ex_ready, wb_excptype); end
    tick();
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL lw_pulse got %b want 0", wb_valid); end
  endtask

  task automatic test_store();
    drive(OP_SW, 32'h0000_0104, 32'hA5A5_A5A5, 32'h7777, 1'b1, 5'd9, 32'h0);
    tick();
    ex_valid = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h104 || mem_wdata !== 32'hA5A5_A5A5) begin
      bad++; $display("FAIL sw_req got %b/%b/%h/%h want 1/1/104/a5a5a5a5", mem_req, mem_we, mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_regcWrite !== 1'b0 || wb_regcData !== 32'h0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL sw_wb got %b/%b/%h/%b want 1/0/0/0", wb_valid, wb_regcWrite, wb_regcData, mem_req); end
    tick();
  endtask

  task automatic test_misaligned();
    drive(OP_LW, 32'h0000_0102, 32'h0, 32'h0, 1'b1, 5'd6, 32'h0);
    tick();
    total++; if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_excptype !== 32'h10 || wb_regcWrite !== 1'b0) begin
      bad++; $display("FAIL lw_misal got %b/%b/%h/%b want 0/1/10/0", mem_req, wb_valid, wb_excptype, wb_regcWrite); end
    drive(OP_SW, 32'h0000_0105, 32'h1111, 32'h0, 1'b1, 5'd7, 32'h0);
    tick();
    ex_valid = 1'b0;
    total++; if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_excptype !== 32'h20 || wb_regcWrite !== 1'b0) begin
      bad++; $display("FAIL sw_misal got %b/%b/%h/%b want 0/1/20/0", mem_req, wb_valid, wb_excptype, wb_regcWrite); end
    tick();
  endtask

  task automatic test_excpt();
    drive(OP_LW, 32'h0000_0200, 32'h0, 32'h0, 1'b1, 5'd8, 32'h0000_0100);
    tick();
    ex_valid = 1'b0;
    total++; if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_excptype !== 32'h100 || wb_regcWrite !== 1'b0) begin
      bad++; $display("FAIL exc_kill got %b/%b/%h/%b want 0/1/100/0", mem_req, wb_valid, wb_excptype, wb_regcWrite); end
    tick();
    total++; if (mem_req !== 1'b0 || ex_ready !== 1'b1) begin
      bad++; $display("FAIL exc_idle got %b/%b want 0/1", mem_req, ex_ready); end
  endtask

  task automatic test_ack_idle();
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_ack = 1'b0;
    total++; if (wb_valid !== 1'b0 || mem_req !== 1'b0 || wb_regcData === 32'hBAD0_BAD0) begin
      bad++; $display("FAIL ack_idle got %b/%b/%h want 0/0/not bad0bad0", wb_valid, mem_req, wb_regcData); end
  endtask

  task automatic test_reset_busy();
    drive(OP_LW, 32'h0000_0300, 32'h0, 32'h0, 1'b1, 5'd10, 32'h0);
    tick();
    ex_valid = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstb_req got %b want 1", mem_req); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin
      bad++; $display("FAIL rstb_drop got %b/%b/%b want 0/0/1", mem_req, wb_valid, ex_ready); end
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rstb_late_ack got %b want 0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    drive(OP_OR, 32'h0, 32'h0, 32'h0000_00AA, 1'b1, 5'd1, 32'h0);
    tick();
    total++; if (wb_valid !== 1'b1 || wb_regcData !== 32'hAA || wb_regcAddr !== 5'd1) begin
      bad++; $display("FAIL b2b_first got %b/%h/%0d want 1/aa/1", wb_valid, wb_regcData, wb_regcAddr); end
    drive(OP_OR, 32'h0, 32'h0, 32'h0000_00BB, 1'b1, 5'd2, 32'h0);
    tick();
    ex_valid = 1'b0;
    total++; if (wb_valid !== 1'b1 || wb_regcData !== 32'hBB || wb_regcAddr !== 5'd2) begin
      bad++; $display("FAIL b2b_second got %b/%h/%0d want 1/bb/2", wb_valid, wb_regcData, wb_regcAddr); end
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_excpt();
    test_ack_idle();
    test_reset_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
